// File: rtl/ahb2apb_ctrl.sv
// AHB-to-APB bridge controller: registers the AHB address phase, then runs one
// APB SETUP/ACCESS sequence per transfer with a two-cycle AHB error response.
module ahb2apb_ctrl #(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_LSB    = 12
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         HSEL,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [31:0]                  HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic [31:0]                  HRDATA,
    output logic [31:0]                  PADDR,
    output logic                         PWRITE,
    output logic [31:0]                  PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL_slave,
    input  logic [NUM_SLAVES-1:0][31:0]  PRData_slave,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        paddr_r;
    logic               pwrite_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_in_s;
    logic               accept_s;
    logic               dec_ok_s;
    logic               take_s;
    logic [NUM_SLAVES-1:0] psel_dec_s;
    logic [31:0]        rdata_sel_s;
    logic               unused_s;

    assign accept_s = HSEL & HTRANS[1] & HREADY;
    assign idx_in_s = HADDR[SEL_LSB +: IDX_W];
    assign dec_ok_s = (32'(idx_in_s) < 32'(NUM_SLAVES));
    assign unused_s = HTRANS[0];

    assign PADDR  = paddr_r;
    assign PWRITE = pwrite_r;
    // The master holds HWDATA while HREADYOUT is low, so no capture register is needed.
    assign PWDATA = HWDATA;

    // Slave select decode and read-data mux from the registered index.
    always_comb begin
        psel_dec_s  = {NUM_SLAVES{1'b0}};
        rdata_sel_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                psel_dec_s[i] = 1'b1;
                rdata_sel_s   = PRData_slave[i];
            end else begin
                psel_dec_s[i] = 1'b0;
            end
        end
    end

    // State register and address-phase capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            paddr_r  <= 32'h0000_0000;
            pwrite_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                paddr_r  <= HADDR;
                pwrite_r <= HWRITE;
                idx_r    <= idx_in_s;
            end
        end
    end

    // Next-state and bus outputs; outputs are forced idle while reset is asserted.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = 32'h0000_0000;
        PENABLE     = 1'b0;
        PSEL_slave  = {NUM_SLAVES{1'b0}};
        if (HRESET) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        take_s      = 1'b1;
                        state_nxt_s = dec_ok_s ? ST_SETUP : ST_ERR1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    HREADYOUT   = 1'b0;
                    PSEL_slave  = psel_dec_s;
                    state_nxt_s = ST_ACCESS;
                end
                ST_ACCESS: begin
                    PSEL_slave = psel_dec_s;
                    PENABLE    = 1'b1;
                    if (!PREADY) begin
                        HREADYOUT   = 1'b0;
                        state_nxt_s = ST_ACCESS;
                    end else if (PSLVERR) begin
                        HREADYOUT   = 1'b0;
                        HRESP       = 1'b1;
                        state_nxt_s = ST_ERR2;
                    end else begin
                        HRDATA = rdata_sel_s;
                        if (accept_s) begin
                            take_s      = 1'b1;
                            state_nxt_s = dec_ok_s ? ST_SETUP : ST_ERR1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end
                ST_ERR1: begin
                    HREADYOUT   = 1'b0;
                    HRESP       = 1'b1;
                    state_nxt_s = ST_ERR2;
                end
                ST_ERR2: begin
                    HRESP = 1'b1;
                    if (accept_s) begin
                        take_s      = 1'b1;
                        state_nxt_s = dec_ok_s ? ST_SETUP : ST_ERR1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb2apb_ctrl.md
AHB2APB_CTRL -- requirements
Module: ahb2apb_ctrl

Interface
REQ-001 Parameter NUM_SLAVES, default 2: number of APB slaves; PSEL_slave width and PRData_slave depth.
REQ-002 Parameter SEL_LSB, default 12: lowest HADDR bit of the slave index field; field width = $clog2(NUM_SLAVES), minimum 1.
REQ-003 HCLK  input  1  single clock; all state updates on rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 HSEL  input  1  bridge selected by the AHB decoder.
REQ-006 HADDR  input  32  AHB address.
REQ-007 HTRANS  input  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
REQ-008 HWRITE  input  1  AHB write flag.
REQ-009 HWDATA  input  32  AHB write data (data phase).
REQ-010 HREADY  input  1  bus-wide ready from the AHB mux.
REQ-011 HREADYOUT  output  1  bridge ready / wait-state.
REQ-012 HRESP  output  1  AHB error response.
REQ-013 HRDATA  output  32  AHB read data.
REQ-014 PADDR  output  32  registered APB address.
REQ-015 PWRITE  output  1  registered APB direction.
REQ-016 PWDATA  output  32  APB write data, equal to HWDATA.
REQ-017 PENABLE  output  1  APB access-phase strobe.
REQ-018 PSEL_slave  output  NUM_SLAVES  one-hot APB slave select.
REQ-019 PRData_slave  input  32 x NUM_SLAVES  per-slave APB read data.
REQ-020 PREADY  input  1  ready from the selected slave.
REQ-021 PSLVERR  input  1  error from the selected slave.

Function
REQ-022 Accept = HSEL & HTRANS[1] & HREADY, sampled at the rising edge; on accept, register HADDR, HWRITE and idx = HADDR[SEL_LSB +: width].
REQ-023 FSM states: IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-024 IDLE: HREADYOUT=1, HRESP=0, PSEL_slave=0, PENABLE=0; on accept go to SETUP if idx < NUM_SLAVES, otherwise to ERR1.
REQ-025 SETUP (exactly one cycle): PSEL_slave[idx]=1, PENABLE=0, HREADYOUT=0; next state ACCESS.
REQ-026 ACCESS: PSEL_slave[idx]=1, PENABLE=1; PREADY=0 -> stay, HREADYOUT=0; PADDR, PWRITE and PSEL_slave are held stable.
REQ-027 ACCESS & PREADY & !PSLVERR: HREADYOUT=1, HRESP=0, HRDATA=PRData_slave[idx]; next state SETUP/ERR1 on a same-cycle accept (per REQ-024 decode), otherwise IDLE.
REQ-028 ACCESS & PREADY & PSLVERR: HREADYOUT=0, HRESP=1; next state ERR2.
REQ-029 ERR1 (decode error, no APB activity): HREADYOUT=0, HRESP=1; next state ERR2.
REQ-030 ERR2: HREADYOUT=1, HRESP=1; on a same-cycle accept decode per REQ-024, otherwise IDLE.
REQ-031 HRDATA=0 except during ACCESS & PREADY & !PSLVERR.
REQ-032 PWDATA=HWDATA combinationally; this is legal because HREADYOUT stays low from SETUP until completion, so the master holds HWDATA.
REQ-033 Minimum latency: 2 cycles from accept to HREADYOUT=1 (SETUP, then ACCESS with PREADY=1); each PREADY=0 cycle adds one wait state.
REQ-034 At most one PSEL_slave bit is set in any cycle; PENABLE=1 only in ACCESS.
REQ-035 Accept with HSEL=0, or HTRANS IDLE/BUSY: no state change; OKAY response.

Reset
REQ-036 HRESET=1 at a clock edge: state IDLE; registered PADDR=0, PWRITE=0 and idx=0.
REQ-037 While in reset, and after it: PSEL_slave=0, PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-038 Reset during SETUP or ACCESS aborts the transfer; PSEL_slave and PENABLE are 0 in the cycle after the reset edge.

Verification
REQ-039 Write: HADDR=0x0000_1004, HWRITE=1, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL_slave=2'b10 for 2 cycles, PENABLE in the 2nd, PADDR=0x0000_1004, PWDATA=0xDEADBEEF, HREADYOUT=1 in the 2nd cycle after accept.
REQ-040 Read from slave 0, PREADY low for 3 ACCESS cycles, PRData_slave[0]=0x1234_5678 -> HREADYOUT low 4 cycles, then HRDATA=0x1234_5678 with HREADYOUT=1, HRESP=0.
REQ-041 Slave error: PREADY=1 and PSLVERR=1 -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1, then IDLE.
REQ-042 NUM_SLAVES=3, HADDR index=3 -> no PSEL_slave bit set; ERR1 then ERR2 two-cycle error response.
REQ-043 Back-to-back: second accept sampled in the completing ACCESS cycle -> SETUP on the next cycle, no IDLE cycle between the transfers.
REQ-044 HRESET=1 asserted in ACCESS with PREADY=0 -> next cycle PSEL_slave=0, PENABLE=0, HREADYOUT=1.
